// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the two-requester shift arbiter.
package shift_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Shift direction encoding on the request ports.
    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    // Requester identifiers as carried on the response tag.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Occupancy of the single result register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/shift_arbiter_core.sv
// Combinational logical barrel shifter, zero fill, no rotate.
module shift_core
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_W = shift_arbiter_pkg::DATA_W,
    parameter int AMT_W  = shift_arbiter_pkg::AMT_W
) (
    input  logic              i_dir,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    // Amount is at most DATA_W-1, so there is no overshift handling.
    always_comb begin
        if (i_dir == SH_RIGHT) begin
            o_dout = i_din >> i_amt;
        end else begin
            o_dout = i_din << i_amt;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// with a single registered result slot on a valid/ready response port.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | result register holds no unconsumed result
// ST_FULL  | result register holds a result awaiting consume
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DATA_W = shift_arbiter_pkg::DATA_W,
    parameter int AMT_W  = shift_arbiter_pkg::AMT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic              i_req0_dir,
    input  logic [AMT_W-1:0]  i_req0_amt,
    input  logic [DATA_W-1:0] i_req0_data,

    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic              i_req1_dir,
    input  logic [AMT_W-1:0]  i_req1_amt,
    input  logic [DATA_W-1:0] i_req1_data,

    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [15:0]       o_rsp_cnt0,
    output logic [15:0]       o_rsp_cnt1
);

    rsp_state_t        r_state;
    rsp_state_t        w_state_nxt;
    logic              r_last_gnt;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;
    logic [15:0]       r_cnt0;
    logic [15:0]       r_cnt1;

    logic              w_rsp_valid;
    logic              w_slot_free;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_consume;
    logic              w_sel_dir;
    logic [AMT_W-1:0]  w_sel_amt;
    logic [DATA_W-1:0] w_sel_data;
    logic [DATA_W-1:0] w_shifted;

    assign w_rsp_valid = (r_state == ST_FULL);
    // Consuming this cycle frees the slot at once, so back-to-back results flow.
    assign w_slot_free = !w_rsp_valid || i_rsp_ready;
    assign w_consume   = w_rsp_valid && i_rsp_ready;

    // Grant: lone requester wins; on contention the one not served last wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = REQ_ID0;
        if (w_slot_free) begin
            if (i_req0_valid && i_req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = !r_last_gnt;
            end else if (i_req0_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ_ID0;
            end else if (i_req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = REQ_ID1;
            end
        end
    end

    assign o_req0_ready = w_gnt_valid && (w_gnt_id == REQ_ID0);
    assign o_req1_ready = w_gnt_valid && (w_gnt_id == REQ_ID1);

    // Operand mux in front of the single shared shifter.
    always_comb begin
        w_sel_dir  = (w_gnt_id == REQ_ID1) ? i_req1_dir  : i_req0_dir;
        w_sel_amt  = (w_gnt_id == REQ_ID1) ? i_req1_amt  : i_req0_amt;
        w_sel_data = (w_gnt_id == REQ_ID1) ? i_req1_data : i_req0_data;
    end

    shift_core #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift_core (
        .i_dir  (w_sel_dir),
        .i_amt  (w_sel_amt),
        .i_din  (w_sel_data),
        .o_dout (w_shifted)
    );

    // Result slot occupancy register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot fills on accept, drains on consume with no simultaneous accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_gnt_valid) w_state_nxt = ST_FULL;
            ST_FULL:  if (i_rsp_ready && !w_gnt_valid) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Load result, tag and round-robin pointer on accept; hold otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_data <= '0;
            r_rsp_id   <= REQ_ID0;
            r_last_gnt <= REQ_ID1;
        end else if (w_gnt_valid) begin
            r_rsp_data <= w_shifted;
            r_rsp_id   <= w_gnt_id;
            r_last_gnt <= w_gnt_id;
        end
    end

    // Delivered-result counters, credited to the tag of the result leaving.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_consume) begin
            if (r_rsp_id == REQ_ID1) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end else begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end
        end
    end

    assign o_rsp_valid = w_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_cnt0  = r_cnt0;
    assign o_rsp_cnt1  = r_cnt1;

endmodule
